// File: rtl/rv_isa_pkg.sv
// RV32I encoder shared definitions: opcodes, format codes, error causes, encoder states.
// Pure declarations; no logic, no latency, no flow control.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    FMT_LUI    = 4'd0,
    FMT_AUIPC  = 4'd1,
    FMT_JAL    = 4'd2,
    FMT_JALR   = 4'd3,
    FMT_BRANCH = 4'd4,
    FMT_LOAD   = 4'd5,
    FMT_STORE  = 4'd6,
    FMT_OPIMM  = 4'd7,
    FMT_OP     = 4'd8,
    FMT_SYSTEM = 4'd9
  } fmt_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_IMM   = 2'd1,
    CAUSE_FMT   = 2'd2,
    CAUSE_ALIGN = 2'd3
  } err_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  function automatic logic [6:0] opcode_of(input logic [3:0] fmt);
    case (fmt)
      FMT_LUI:    return OPC_LUI;
      FMT_AUIPC:  return OPC_AUIPC;
      FMT_JAL:    return OPC_JAL;
      FMT_JALR:   return OPC_JALR;
      FMT_BRANCH: return OPC_BRANCH;
      FMT_LOAD:   return OPC_LOAD;
      FMT_STORE:  return OPC_STORE;
      FMT_OPIMM:  return OPC_OPIMM;
      FMT_OP:     return OPC_OP;
      FMT_SYSTEM: return OPC_SYSTEM;
      default:    return 7'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range and alignment checks.
// Zero latency; no flow control. A rejected request yields instr=0 and a cause code.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        ok,
  output logic [1:0]  cause
);

  logic signed [31:0] simm;
  logic [31:0] raw;
  logic [6:0]  opc;
  logic        fmt_ok, mis, rng_bad;
  logic        i_ok, b_ok, j_ok, shift;

  assign simm  = imm;
  assign opc   = opcode_of(fmt);
  assign i_ok  = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
  assign b_ok  = (simm >= -32'sd4096)    && (simm <= 32'sd4094);
  assign j_ok  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
  assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    raw     = '0;
    fmt_ok  = 1'b1;
    mis     = 1'b0;
    rng_bad = 1'b0;
    case (fmt)
      FMT_LUI, FMT_AUIPC: begin
        raw     = {imm[31:12], rd, opc};
        rng_bad = |imm[11:0];
      end
      FMT_JAL: begin
        raw     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        mis     = imm[0];
        rng_bad = !j_ok;
      end
      FMT_JALR: begin
        raw     = {imm[11:0], rs1, 3'b000, rd, opc};
        rng_bad = !i_ok;
      end
      FMT_BRANCH: begin
        raw     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc};
        mis     = imm[0];
        rng_bad = !b_ok;
      end
      FMT_LOAD: begin
        raw     = {imm[11:0], rs1, funct3, rd, opc};
        rng_bad = !i_ok;
      end
      FMT_STORE: begin
        raw     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc};
        rng_bad = !i_ok;
      end
      FMT_OPIMM: begin
        // Shifts carry the funct7 qualifier above a 5-bit shamt.
        if (shift) begin
          raw     = {funct7, imm[4:0], rs1, funct3, rd, opc};
          rng_bad = |imm[31:5];
        end else begin
          raw     = {imm[11:0], rs1, funct3, rd, opc};
          rng_bad = !i_ok;
        end
      end
      FMT_OP: begin
        raw = {funct7, rs2, rs1, funct3, rd, opc};
      end
      FMT_SYSTEM: begin
        raw     = {imm[11:0], rs1, funct3, rd, opc};
        rng_bad = |imm[31:12];
      end
      default: fmt_ok = 1'b0;
    endcase

    cause = CAUSE_NONE;
    if (!fmt_ok)     cause = CAUSE_FMT;
    else if (mis)    cause = CAUSE_ALIGN;
    else if (rng_bad) cause = CAUSE_IMM;
    ok    = (cause == CAUSE_NONE);
    instr = ok ? raw : '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: one output register, 1-cycle accept-to-valid latency.
// Output holds while out_ready is low; in_ready drops then, allowing full-rate drain+accept.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            fmt,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_addr,
  output logic                  err,
  output logic [1:0]            err_cause,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

  enc_state_e state, state_nxt;
  logic [31:0] pk_instr;
  logic        pk_ok;
  logic [1:0]  pk_cause;
  logic        accept, good, bad, drain;
  logic [DEPTH_LOG2+1:0] loaded_nxt;

  instr_pack u_pack (
    .fmt    (fmt),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .instr  (pk_instr),
    .ok     (pk_ok),
    .cause  (pk_cause)
  );

  assign accept = in_valid && in_ready;
  assign good   = accept && pk_ok;
  assign bad    = accept && !pk_ok;
  assign drain  = out_valid && out_ready;
  // Words loaded so far (drained + pending) once this accept lands.
  assign loaded_nxt = {1'b0, count} + (DEPTH_LOG2 + 2)'(out_valid) + (DEPTH_LOG2 + 2)'(1);
  assign out_addr   = BASE_ADDR + 32'({count, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN: begin
        if (bad)                                        state_nxt = ST_ERR;
        else if (good && (loaded_nxt == {1'b0, CAP}))   state_nxt = ST_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    err      = (state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      count     <= '0;
      err_cause <= CAUSE_NONE;
    end else begin
      if (good) begin
        out_valid <= 1'b1;
        out_instr <= pk_instr;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain && (count != CAP)) count <= count + (DEPTH_LOG2 + 1)'(1);
      if (bad) err_cause <= pk_cause;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus randomized traffic against a reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  fmt = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        b_in_ready, b_out_valid, b_err, s_in_ready, s_out_valid, s_err;
  logic [31:0] b_out_instr, b_out_addr, s_out_instr, s_out_addr;
  logic [1:0]  b_err_cause, s_err_cause;
  logic [10:0] b_count;
  logic [2:0]  s_count;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH_LOG2(10)) u_big (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr), .out_addr(b_out_addr),
    .err(b_err), .err_cause(b_err_cause), .count(b_count)
  );

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr),
    .err(s_err), .err_cause(s_err_cause), .count(s_count)
  );

  // Both instances see identical stimulus; sel picks the one the model follows.
  bit sel = 1'b0;
  logic        o_in_ready, o_out_valid, o_err;
  logic [31:0] o_out_instr, o_out_addr;
  logic [1:0]  o_err_cause;
  logic [10:0] o_count;
  assign o_in_ready  = sel ? s_in_ready  : b_in_ready;
  assign o_out_valid = sel ? s_out_valid : b_out_valid;
  assign o_err       = sel ? s_err       : b_err;
  assign o_out_instr = sel ? s_out_instr : b_out_instr;
  assign o_out_addr  = sel ? s_out_addr  : b_out_addr;
  assign o_err_cause = sel ? s_err_cause : b_err_cause;
  assign o_count     = sel ? 11'(s_count) : b_count;

  int n_chk = 0, n_fail = 0;
  int m_st, m_cnt, m_loaded, m_cause;   // m_st: 0 idle, 1 run, 2 err, 3 done
  logic [31:0] sb[$];
  bit last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_enc(input logic [31:0] f, f3, f7, r_d, r_s1, r_s2, im,
                                 output logic [31:0] w);
    int s, c;
    logic [31:0] opc [10];
    opc = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33, 32'h73};
    s = signed'(im);
    c = 0;
    w = 0;
    if (f > 9) return 2;
    case (f)
      0, 1: begin
        if ((im & 32'hFFF) != 0) c = 1;
        w = (im & 32'hFFFFF000) | (r_d << 7);
      end
      2: begin
        if (s % 2 != 0) c = 3;
        else if (s < -(1 << 20) || s > (1 << 20) - 2) c = 1;
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (r_d << 7);
      end
      3: begin
        if (s < -2048 || s > 2047) c = 1;
        w = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (r_d << 7);
      end
      4: begin
        if (s % 2 != 0) c = 3;
        else if (s < -4096 || s > 4094) c = 1;
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r_s2 << 20) |
            (r_s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
      end
      5: begin
        if (s < -2048 || s > 2047) c = 1;
        w = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7);
      end
      6: begin
        if (s < -2048 || s > 2047) c = 1;
        w = (((im >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) |
            ((im & 32'h1F) << 7);
      end
      7: begin
        if (f3 == 1 || f3 == 5) begin
          if (s < 0 || s > 31) c = 1;
          w = (f7 << 25) | ((im & 32'h1F) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7);
        end else begin
          if (s < -2048 || s > 2047) c = 1;
          w = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7);
        end
      end
      8: w = (f7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7);
      default: begin
        if (s < 0 || s > 4095) c = 1;
        w = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7);
      end
    endcase
    w = (c != 0) ? 32'h0 : (w | opc[f]);
    return c;
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    bit exp_rdy, acc, drn;
    int c;
    logic [31:0] w;
    #1;
    exp_rdy = (m_st == 1) && (sb.size() == 0 || out_ready);
    check("in_ready", o_in_ready, exp_rdy);
    check("out_valid", o_out_valid, sb.size() != 0);
    check("count", o_count, m_cnt);
    check("err", o_err, m_st == 2);
    check("err_cause", o_err_cause, (m_st == 2) ? m_cause : 0);
    acc = in_valid && exp_rdy;
    drn = (sb.size() != 0) && out_ready;
    if (sb.size() != 0) begin
      check("out_instr", o_out_instr, sb[0]);
      check("out_addr", o_out_addr, 4 * m_cnt);
    end
    last_acc = acc;
    if (clear) begin
      m_st = 0; m_cnt = 0; m_loaded = 0; m_cause = 0;
      sb.delete();
    end else begin
      if (drn) begin
        void'(sb.pop_front());
        m_cnt++;
      end
      if (m_st == 0) m_st = 1;
      else if (acc) begin
        c = ref_enc(fmt, funct3, funct7, rd, rs1, rs2, imm, w);
        if (c != 0) begin
          m_st = 2;
          m_cause = c;
        end else begin
          sb.push_back(w);
          m_loaded++;
          if (m_loaded == (sel ? 4 : 1024)) m_st = 3;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_instr", o_out_instr, 0);
    check("rst_out_addr", o_out_addr, 0);
    check("rst_err", o_err, 0);
    check("rst_err_cause", o_err_cause, 0);
    check("rst_count", o_count, 0);
    check("rst_in_ready", o_in_ready, 0);
    rst_n = 1'b1;
    m_st = 0; m_cnt = 0; m_loaded = 0; m_cause = 0;
    sb.delete();
  endtask

  task automatic set_req(input int f, input int f3, input int f7, input int r_d,
                         input int r_s1, input int r_s2, input logic [31:0] im);
    fmt = 4'(f); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(r_d); rs1 = 5'(r_s1); rs2 = 5'(r_s2); imm = im;
  endtask

  task automatic send();
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) tick();
    check("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rand_req();
    int r;
    fmt    = ($urandom_range(0, 19) == 0) ? 4'(10 + $urandom_range(0, 5)) : 4'($urandom_range(0, 9));
    funct3 = 3'($urandom_range(0, 7));
    funct7 = 7'($urandom_range(0, 127));
    rd     = 5'($urandom_range(0, 31));
    rs1    = 5'($urandom_range(0, 31));
    rs2    = 5'($urandom_range(0, 31));
    r = $urandom_range(0, 9);
    if (r < 6) begin
      imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
    end else if (r == 6) imm = $urandom;
    else if (r == 7) imm = $urandom & 32'hFFFFF000;
    else if (r == 8) imm = 32'($urandom_range(0, 31));
    else imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  logic [31:0] seq_w [5];
  initial begin
    seq_w = '{32'h123452B7, 32'h008000EF, 32'hFE208EE3, 32'h0020A423, 32'h402081B3};
    @(negedge clk);

    // single OPIMM, 1-cycle latency
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    set_req(7, 0, 0, 1, 0, 0, 32'd5);
    send();
    check("addi_instr", o_out_instr, 32'h00500093);
    check("addi_addr", o_out_addr, 32'h0);
    check("addi_valid", o_out_valid, 1);

    // five-word stream with no back-pressure
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: set_req(0, 0, 0, 5, 0, 0, 32'h12345000);
        1: set_req(2, 0, 0, 1, 0, 0, 32'd8);
        2: set_req(4, 0, 0, 0, 1, 2, 32'hFFFFFFFC);
        3: set_req(6, 2, 0, 0, 1, 2, 32'd8);
        default: set_req(8, 0, 7'h20, 3, 1, 2, 32'd0);
      endcase
      send();
      check("seq_instr", o_out_instr, seq_w[i]);
      check("seq_addr", o_out_addr, 4 * i);
    end

    // back-pressure holds the OP word, then the JALR follows with no bubble
    out_ready = 1'b0;
    set_req(3, 7, 0, 1, 2, 0, 32'd16);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_instr", o_out_instr, 32'h402081B3);
      check("bp_addr", o_out_addr, 32'd16);
      check("bp_in_ready", o_in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("nb_valid", o_out_valid, 1);
    check("nb_instr", o_out_instr, 32'h010100E7);
    check("nb_addr", o_out_addr, 32'd20);
    tick();

    // error causes
    do_reset();
    out_ready = 1'b1;
    set_req(7, 0, 0, 1, 0, 0, 32'd2048);
    send();
    check("e_imm_err", o_err, 1);
    check("e_imm_cause", o_err_cause, 1);
    check("e_imm_valid", o_out_valid, 0);
    in_valid = 1'b1;
    repeat (3) tick();
    check("e_imm_in_ready", o_in_ready, 0);
    pulse_clear();
    set_req(4, 0, 0, 0, 1, 2, 32'd3);
    send();
    check("e_align_cause", o_err_cause, 3);
    pulse_clear();
    set_req(12, 0, 0, 0, 0, 0, 32'd0);
    send();
    check("e_fmt_cause", o_err_cause, 2);
    pulse_clear();
    check("e_clear_err", o_err, 0);

    // capacity on the 4-word instance
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    set_req(7, 0, 0, 2, 2, 0, 32'd1);
    in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    check("done_count", o_count, 4);
    check("done_in_ready", o_in_ready, 0);
    pulse_clear();
    check("clr_count", o_count, 0);
    send();
    check("clr_addr", o_out_addr, 0);
    check("clr_valid", o_out_valid, 1);

    // reset with a word stuck at the output
    sel = 1'b0;
    do_reset();
    out_ready = 1'b0;
    set_req(9, 0, 0, 0, 0, 0, 32'd1);
    send();
    check("pre_rst_valid", o_out_valid, 1);
    do_reset();

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_reset();
      for (int i = 0; i < 700; i++) begin
        rand_req();
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        clear     = (m_st == 2 || m_st == 3 || $urandom_range(0, 49) == 0);
        tick();
      end
      clear = 1'b0;
      in_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
